// File: rtl/mod60_seq_ctrl.sv
// mod60_seq_ctrl: run controller for a 10x6 mod-60 BCD counter pair with prescaled tick, up/down and preload
// Ports: clk; rst (async, active-low); start/pause/clear/load level commands (clear > load > start/pause);
//        load_10/load_6 preload digits; dir (0=up,1=down, latched on start);
//        cnt_10/cnt_6 BCD digits; cout one-cycle up-wrap pulse; done high in DONE; state IDLE/RUN/PAUSE/DONE
module mod60_seq_ctrl #(
  parameter int DIV       = 1,
  parameter int CNT10_MAX = 9,
  parameter int CNT6_MAX  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_10,
  input  logic [3:0] load_6,
  input  logic       dir,
  output logic [3:0] cnt_10,
  output logic [3:0] cnt_6,
  output logic       cout,
  output logic       done,
  output logic [1:0] state
);
  localparam int PW = $clog2(DIV) + 1;
  localparam logic [3:0] M10 = 4'(CNT10_MAX);
  localparam logic [3:0] M6  = 4'(CNT6_MAX);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t r_state, w_state;
  logic [3:0] r_c10, r_c6, w_c10, w_c6;
  logic [PW-1:0] r_pre, w_pre;
  logic r_dir, w_dir, r_cout, w_cout, r_done;
  logic w_tick, w_zero, w_wrap, w_load_ok, w_start_ok, w_pause_ok;
  logic [3:0] w_up10, w_up6, w_dn10, w_dn6;
  assign w_tick     = r_pre == PW'(DIV - 1);
  assign w_zero     = r_c10 == 4'd0 && r_c6 == 4'd0;
  assign w_wrap     = r_c10 == M10 && r_c6 == M6;
  assign w_up10     = r_c10 == M10 ? 4'd0 : r_c10 + 4'd1;
  assign w_up6      = r_c10 == M10 ? (r_c6 == M6 ? 4'd0 : r_c6 + 4'd1) : r_c6;
  assign w_dn10     = r_c10 == 4'd0 ? M10 : r_c10 - 4'd1;
  assign w_dn6      = r_c10 == 4'd0 ? r_c6 - 4'd1 : r_c6;
  assign w_load_ok  = load && r_state != RUN;
  assign w_start_ok = start && !pause && (r_state == IDLE || r_state == PAUSE);
  assign w_pause_ok = pause && !start && r_state == RUN;
  always_comb begin
    w_state = r_state;
    w_c10   = r_c10;
    w_c6    = r_c6;
    w_pre   = r_pre;
    w_dir   = r_dir;
    w_cout  = 1'b0;
    if (clear) begin
      w_state = IDLE;
      w_c10   = 4'd0;
      w_c6    = 4'd0;
      w_pre   = '0;
    end else if (w_load_ok) begin
      w_c10   = load_10 > M10 ? M10 : load_10;
      w_c6    = load_6 > M6 ? M6 : load_6;
      w_state = r_state == DONE ? IDLE : r_state;
    end else if (w_start_ok) begin
      w_dir   = dir;
      // a down-count from 00 has nothing to do, so it finishes without a RUN cycle
      w_state = dir && w_zero ? DONE : RUN;
      w_pre   = r_state == IDLE ? '0 : r_pre;
    end else if (w_pause_ok) begin
      w_state = PAUSE;
    end else if (r_state == RUN) begin
      w_pre = w_tick ? '0 : r_pre + 1'b1;
      if (w_tick && !r_dir) begin
        w_c10  = w_up10;
        w_c6   = w_up6;
        w_cout = w_wrap;
      end else if (w_tick && !w_zero) begin
        w_c10   = w_dn10;
        w_c6    = w_dn6;
        w_state = w_dn10 == 4'd0 && w_dn6 == 4'd0 ? DONE : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_c10   <= 4'd0;
      r_c6    <= 4'd0;
      r_pre   <= '0;
      r_dir   <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_c10   <= w_c10;
      r_c6    <= w_c6;
      r_pre   <= w_pre;
      r_dir   <= w_dir;
      r_cout  <= w_cout;
      r_done  <= w_state == DONE;
    end
  end
  assign cnt_10 = r_c10;
  assign cnt_6  = r_c6;
  assign cout   = r_cout;
  assign done   = r_done;
  assign state  = r_state;
endmodule

// File: tb/tb_mod60_seq_ctrl.sv
// tb_mod60_seq_ctrl: scoreboard bench for mod60_seq_ctrl with DIV=1 and DIV=4 instances on shared inputs
module tb_mod60_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
  logic [3:0] load_10 = 4'd0, load_6 = 4'd0;
  logic [3:0] c10_a, c6_a, c10_b, c6_b;
  logic cout_a, done_a, cout_b, done_b;
  logic [1:0] st_a, st_b;
  int tests = 0, fails = 0;
  typedef struct {
    bit sel;
    logic [3:0] c10;
    logic [3:0] c6;
    logic co;
    logic [1:0] st;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  always #5 clk = ~clk;
  mod60_seq_ctrl #(.DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .load(load),
    .load_10(load_10), .load_6(load_6), .dir(dir),
    .cnt_10(c10_a), .cnt_6(c6_a), .cout(cout_a), .done(done_a), .state(st_a)
  );
  mod60_seq_ctrl #(.DIV(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .load(load),
    .load_10(load_10), .load_6(load_6), .dir(dir),
    .cnt_10(c10_b), .cnt_6(c6_b), .cout(cout_b), .done(done_b), .state(st_b)
  );
  function automatic logic [11:0] act(input bit sel);
    return sel ? {c10_b, c6_b, cout_b, done_b, st_b} : {c10_a, c6_a, cout_a, done_a, st_a};
  endfunction
  task automatic check(input string name, input logic [11:0] a, input logic [11:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got c10=%0d c6=%0d cout=%b done=%b st=%b, expected c10=%0d c6=%0d cout=%b done=%b st=%b",
               name, a[11:8], a[7:4], a[3], a[2], a[1:0], e[11:8], e[7:4], e[3], e[2], e[1:0]);
    end
  endtask
  task automatic step(input bit sel, input logic [3:0] c10, input logic [3:0] c6, input logic co,
                      input logic [1:0] st, input string name);
    q.push_back('{sel, c10, c6, co, st, name});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      check(m_e.name, act(m_e.sel), {m_e.c10, m_e.c6, m_e.co, m_e.st == 2'd3, m_e.st});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_a", act(0), 12'd0);
    check("reset_b", act(1), 12'd0);
    rst = 1'b1;
    @(negedge clk);
    dir = 1'b0;
    start = 1'b1;
    step(0, 0, 0, 0, 2'd1, "t1_start");
    for (int k = 1; k < 60; k++) step(0, 4'(k % 10), 4'(k / 10), 0, 2'd1, "t1_up");
    step(0, 0, 0, 1, 2'd1, "t1_wrap");
    step(0, 1, 0, 0, 2'd1, "t1_post_wrap");
    clear = 1'b1;
    step(0, 0, 0, 0, 2'd0, "t1_clear");
    start = 1'b1;
    step(1, 0, 0, 0, 2'd1, "t2_start");
    for (int e = 1; e < 30; e++) step(1, 4'(e / 4), 0, 0, 2'd1, "t2_run");
    pause = 1'b1;
    step(1, 7, 0, 0, 2'd2, "t2_pause");
    repeat (10) step(1, 7, 0, 0, 2'd2, "t2_hold");
    start = 1'b1;
    step(1, 7, 0, 0, 2'd1, "t2_resume");
    step(1, 7, 0, 0, 2'd1, "t2_pre2");
    step(1, 7, 0, 0, 2'd1, "t2_pre3");
    step(1, 8, 0, 0, 2'd1, "t2_tick");
    clear = 1'b1;
    step(1, 0, 0, 0, 2'd0, "t2_clear");
    load = 1'b1;
    load_10 = 4'd3;
    load_6 = 4'd1;
    step(0, 3, 1, 0, 2'd0, "t3_load");
    dir = 1'b1;
    start = 1'b1;
    step(0, 3, 1, 0, 2'd1, "t3_start");
    for (int k = 12; k > 0; k--) step(0, 4'(k % 10), 4'(k / 10), 0, 2'd1, "t3_down");
    step(0, 0, 0, 0, 2'd3, "t3_done");
    repeat (20) step(0, 0, 0, 0, 2'd3, "t3_hold");
    start = 1'b1;
    step(0, 0, 0, 0, 2'd3, "t3_start_in_done");
    load = 1'b1;
    load_10 = 4'd5;
    load_6 = 4'd0;
    step(0, 5, 0, 0, 2'd0, "t3_load_in_done");
    load = 1'b1;
    load_10 = 4'd12;
    load_6 = 4'd7;
    step(0, 9, 5, 0, 2'd0, "t4_clamp");
    dir = 1'b0;
    start = 1'b1;
    step(0, 9, 5, 0, 2'd1, "t4_start");
    step(0, 0, 0, 1, 2'd1, "t4_wrap");
    step(0, 1, 0, 0, 2'd1, "t4_post_wrap");
    for (int k = 2; k <= 42; k++) step(0, 4'(k % 10), 4'(k / 10), 0, 2'd1, "t5_up");
    load = 1'b1;
    load_10 = 4'd3;
    load_6 = 4'd3;
    step(0, 3, 4, 0, 2'd1, "t5_load_in_run");
    start = 1'b1;
    pause = 1'b1;
    step(0, 4, 4, 0, 2'd1, "t5_start_pause");
    clear = 1'b1;
    start = 1'b1;
    step(0, 0, 0, 0, 2'd0, "t5_clear_start");
    dir = 1'b1;
    start = 1'b1;
    step(0, 0, 0, 0, 2'd3, "t5_down_from_zero");
    clear = 1'b1;
    step(0, 0, 0, 0, 2'd0, "t5_clear_done");
    dir = 1'b0;
    start = 1'b1;
    step(0, 0, 0, 0, 2'd1, "t6_start");
    step(0, 1, 0, 0, 2'd1, "t6_run");
    #2 rst = 1'b0;
    #1;
    check("t6_async_a", act(0), 12'd0);
    check("t6_async_b", act(1), 12'd0);
    @(negedge clk);
    rst = 1'b1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
